// File: rtl/spi_target_byte.sv
// spi_target_byte
//   Fabric-side SPI target, mode 0 (CPOL=0, CPHA=0), MSB first. All SPI pins are
//   oversampled in the sys_clk domain. Received words are presented on a
//   valid-only interface. Response words are accepted through a one-entry
//   valid/ready holding register.
//
// Ports
//   sys_clk      : system clock, all logic on the rising edge
//   reset_n      : synchronous active-low reset
//   sclk/nss/mosi: asynchronous SPI pins from the master
//   miso         : target-out data bit
//   miso_oe      : high while a frame is active; the pad drives miso only when set
//   rx_data      : last complete received word
//   rx_valid     : 1-cycle pulse when rx_data updates
//   tx_data      : next response word
//   tx_valid     : tx_data offered
//   tx_ready     : holding register empty (transfer on tx_valid & tx_ready)
//   tx_underrun  : 1-cycle pulse when DUMMY_WORD was loaded from an empty holding register
//   frame_active : FSM is in the SHIFT state
module spi_target_byte #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DUMMY_WORD  = {DATA_W{1'b1}}
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              nss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_active
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    // Pin synchronisers plus one history flop for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q, nss_sync_q, mosi_sync_q;
    logic                   sclk_hist_q, nss_hist_q;
    logic                   sclk_s, nss_s, mosi_s;
    logic                   sclk_rise, sclk_fall, nss_rise, nss_fall;

    // Holding register and shifters.
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic [DATA_W-2:0] shift_tx_q;   // bits still to be sent after the one on miso
    logic [DATA_W-2:0] rx_shift_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              word_done_q;
    state_e            state_q;

    logic              miso_q, miso_oe_q, rx_valid_q, tx_underrun_q, frame_active_q;
    logic [DATA_W-1:0] rx_data_q;

    logic              load_d;
    logic              tx_write_d;
    logic [DATA_W-1:0] next_word_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign nss_s  = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign nss_rise  = nss_s & ~nss_hist_q;
    assign nss_fall  = ~nss_s & nss_hist_q;

    // nss flops reset low: a select held low through reset looks like "no edge"
    // until the master deselects and selects again.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            nss_sync_q  <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            nss_hist_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_hist_q <= sclk_s;
            nss_hist_q  <= nss_s;
        end
    end

    // A load happens at frame start and on the sclk fall after a completed word;
    // nss rise wins over a coincident sclk fall, so no load then.
    always_comb begin
        load_d      = ((state_q == ST_IDLE) && nss_fall) ||
                      ((state_q == ST_SHIFT) && !nss_rise && sclk_fall && word_done_q);
        tx_write_d  = tx_valid && !hold_full_q;
        next_word_d = hold_full_q ? hold_q : DUMMY_WORD;
    end

    // A write coinciding with a load from an empty register is still captured;
    // the load itself sees the old empty state and takes DUMMY_WORD.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else if (load_d && hold_full_q) begin
            hold_full_q <= 1'b0;
        end else if (tx_write_d) begin
            hold_q      <= tx_data;
            hold_full_q <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            tx_underrun_q  <= 1'b0;
            frame_active_q <= 1'b0;
            bit_cnt_q      <= '0;
            word_done_q    <= 1'b0;
            shift_tx_q     <= '0;
            rx_shift_q     <= '0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (nss_fall) begin
                        shift_tx_q     <= next_word_d[DATA_W-2:0];
                        miso_q         <= next_word_d[DATA_W-1];
                        tx_underrun_q  <= ~hold_full_q;
                        miso_oe_q      <= 1'b1;
                        frame_active_q <= 1'b1;
                        bit_cnt_q      <= '0;
                        word_done_q    <= 1'b0;
                        state_q        <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (nss_rise) begin
                        miso_q         <= 1'b0;
                        miso_oe_q      <= 1'b0;
                        frame_active_q <= 1'b0;
                        bit_cnt_q      <= '0;
                        word_done_q    <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_s};
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            rx_data_q   <= {rx_shift_q, mosi_s};
                            rx_valid_q  <= 1'b1;
                            bit_cnt_q   <= '0;
                            word_done_q <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        if (word_done_q) begin
                            shift_tx_q    <= next_word_d[DATA_W-2:0];
                            miso_q        <= next_word_d[DATA_W-1];
                            tx_underrun_q <= ~hold_full_q;
                            word_done_q   <= 1'b0;
                        end else begin
                            miso_q     <= shift_tx_q[DATA_W-2];
                            shift_tx_q <= {shift_tx_q[DATA_W-3:0], 1'b0};
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = miso_oe_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_ready     = ~hold_full_q;
    assign tx_underrun  = tx_underrun_q;
    assign frame_active = frame_active_q;

endmodule
